// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline defines: register-file geometry, hazard-controller state and default widths.
// Imported by pipe_hazard_ctrl and raw_hazard_cmp.
package pipe_hazard_ctrl_pkg;

   localparam int REG_FILE_ADDR_LEN = 32;
   localparam int REG_ADDR_W_DEF    = $clog2(REG_FILE_ADDR_LEN);
   localparam int CNT_W_DEF         = 16;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_raw_hazard_cmp.sv
// Read-after-write match of the ID source registers against one in-flight destination.
// Purely combinational; register 0 is hardwired and never matches.
module raw_hazard_cmp
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic [REG_ADDR_W-1:0] rs_i,
   input  logic [REG_ADDR_W-1:0] rt_i,
   input  logic                  uses_rt_i,
   input  logic [REG_ADDR_W-1:0] dest_i,
   input  logic                  dest_vld_i,
   output logic                  hit_o
);

   logic dest_nz;

   assign dest_nz = (dest_i != '0);
   assign hit_o   = dest_vld_i && dest_nz &&
                    ((dest_i == rs_i) || (uses_rt_i && (dest_i == rt_i)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, taken-branch flush and load-use bubble.
// Define NO_FORWARD_STALL_EN for a forwarding-less pipeline (stall on every EXE/MEM RAW).
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rt,
   input  logic [REG_ADDR_W-1:0] exe_dest,
   input  logic                  exe_wb_en,
   input  logic                  exe_mem_read,
   input  logic [REG_ADDR_W-1:0] mem_dest,
   input  logic                  mem_wb_en,
   input  logic                  branch_taken,
   input  logic                  mem_req,
   input  logic                  mem_ready,
   output logic                  pc_hold,
   output logic                  if2id_hold,
   output logic                  if2id_flush,
   output logic                  id2exe_hold,
   output logic                  id2exe_bubble,
   output logic                  exe2mem_hold,
   output logic [CNT_W-1:0]      stall_cnt
);

   hz_state_e        state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             freeze;
   logic             hazard;
   logic             load_hit;

   raw_hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_exe_load_cmp (
      .rs_i       (id_rs),
      .rt_i       (id_rt),
      .uses_rt_i  (id_uses_rt),
      .dest_i     (exe_dest),
      .dest_vld_i (exe_wb_en & exe_mem_read),
      .hit_o      (load_hit)
   );

`ifdef NO_FORWARD_STALL_EN
   logic exe_hit;
   logic mem_hit;

   raw_hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_exe_raw_cmp (
      .rs_i       (id_rs),
      .rt_i       (id_rt),
      .uses_rt_i  (id_uses_rt),
      .dest_i     (exe_dest),
      .dest_vld_i (exe_wb_en),
      .hit_o      (exe_hit)
   );

   raw_hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_mem_raw_cmp (
      .rs_i       (id_rs),
      .rt_i       (id_rt),
      .uses_rt_i  (id_uses_rt),
      .dest_i     (mem_dest),
      .dest_vld_i (mem_wb_en),
      .hit_o      (mem_hit)
   );

   assign hazard = load_hit | exe_hit | mem_hit;
`else
   // Forwarding covers everything except a load feeding the very next instruction.
   assign hazard = load_hit;
`endif

   always_comb begin
      state_d       = state_q;
      freeze        = 1'b0;
      pc_hold       = 1'b0;
      if2id_hold    = 1'b0;
      if2id_flush   = 1'b0;
      id2exe_hold   = 1'b0;
      id2exe_bubble = 1'b0;
      exe2mem_hold  = 1'b0;

      case (state_q)
         RUN: begin
            if (mem_req && !mem_ready) begin
               freeze  = 1'b1;
               state_d = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            if (mem_ready) state_d = RUN;
            else           freeze  = 1'b1;
         end
         default: state_d = RUN;
      endcase

      // A branch seen while frozen is deliberately dropped; it is acted on once the freeze lifts.
      if (rst) begin
         state_d = RUN;
      end else if (freeze) begin
         pc_hold      = 1'b1;
         if2id_hold   = 1'b1;
         id2exe_hold  = 1'b1;
         exe2mem_hold = 1'b1;
      end else if (branch_taken) begin
         if2id_flush   = 1'b1;
         id2exe_bubble = 1'b1;
      end else if (hazard) begin
         pc_hold       = 1'b1;
         if2id_hold    = 1'b1;
         id2exe_bubble = 1'b1;
      end

      stall_cnt_d = stall_cnt_q;
      if (pc_hold && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: expected controls queued at drive time, compared at negedge.
// A second instance with a 3-bit counter exercises saturation.
module tb_pipe_hazard_ctrl;
   import pipe_hazard_ctrl_pkg::*;

   localparam int AW = 5;
   localparam int CW = 16;
   localparam int SW = 3;
`ifdef NO_FORWARD_STALL_EN
   localparam bit NOFWD = 1'b1;
`else
   localparam bit NOFWD = 1'b0;
`endif

   // {pc_hold, if2id_hold, if2id_flush, id2exe_hold, id2exe_bubble, exe2mem_hold}
   localparam logic [5:0] C_NONE = 6'b000000;
   localparam logic [5:0] C_FRZ  = 6'b110101;
   localparam logic [5:0] C_LU   = 6'b110010;
   localparam logic [5:0] C_BR   = 6'b001010;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [AW-1:0] id_rs, id_rt, exe_dest, mem_dest;
   logic          id_uses_rt, exe_wb_en, exe_mem_read, mem_wb_en;
   logic          branch_taken, mem_req, mem_ready;

   logic          pc_hold, if2id_hold, if2id_flush, id2exe_hold, id2exe_bubble, exe2mem_hold;
   logic [CW-1:0] stall_cnt;
   logic          s_pc_hold, s_if2id_hold, s_if2id_flush, s_id2exe_hold, s_id2exe_bubble, s_exe2mem_hold;
   logic [SW-1:0] s_stall_cnt;

   logic [5:0] ctl;
   assign ctl = {pc_hold, if2id_hold, if2id_flush, id2exe_hold, id2exe_bubble, exe2mem_hold};

   pipe_hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
      .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_hold(pc_hold), .if2id_hold(if2id_hold), .if2id_flush(if2id_flush),
      .id2exe_hold(id2exe_hold), .id2exe_bubble(id2exe_bubble), .exe2mem_hold(exe2mem_hold),
      .stall_cnt(stall_cnt)
   );

   pipe_hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(SW)) dut_sat (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
      .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_hold(s_pc_hold), .if2id_hold(s_if2id_hold), .if2id_flush(s_if2id_flush),
      .id2exe_hold(s_id2exe_hold), .id2exe_bubble(s_id2exe_bubble), .exe2mem_hold(s_exe2mem_hold),
      .stall_cnt(s_stall_cnt)
   );

   typedef struct {
      logic          rst;
      logic [AW-1:0] rs, rt;
      logic          uses_rt;
      logic [AW-1:0] exe_dest;
      logic          exe_wb_en, exe_mem_read;
      logic [AW-1:0] mem_dest;
      logic          mem_wb_en, branch, mem_req, mem_ready;
   } stim_t;

   typedef struct {
      logic [5:0]    ctl;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t  sb[$];
   stim_t st_q[$];
   exp_t  ex_q[$];
   exp_t  e;
   int    checks = 0;
   int    errors = 0;

   function automatic stim_t idle();
      stim_t s;
      s = '{rst: 1'b0, rs: '0, rt: '0, uses_rt: 1'b0, exe_dest: '0, exe_wb_en: 1'b0,
            exe_mem_read: 1'b0, mem_dest: '0, mem_wb_en: 1'b0, branch: 1'b0,
            mem_req: 1'b0, mem_ready: 1'b0};
      return s;
   endfunction

   function automatic stim_t lw(input logic [AW-1:0] dest, input logic [AW-1:0] rs);
      stim_t s;
      s = idle();
      s.exe_dest = dest; s.exe_wb_en = 1'b1; s.exe_mem_read = 1'b1; s.rs = rs;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      rst = s.rst; id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.uses_rt;
      exe_dest = s.exe_dest; exe_wb_en = s.exe_wb_en; exe_mem_read = s.exe_mem_read;
      mem_dest = s.mem_dest; mem_wb_en = s.mem_wb_en; branch_taken = s.branch;
      mem_req = s.mem_req; mem_ready = s.mem_ready;
   endtask

   task automatic add(input stim_t s, input logic [5:0] c, input logic [CW-1:0] n);
      exp_t x;
      x.ctl = c; x.cnt = n;
      st_q.push_back(s); ex_q.push_back(x);
   endtask

   task automatic do_reset();
      stim_t s;
      s = idle(); s.rst = 1'b1;
      apply(s);
      @(posedge clk); #1;
      apply(idle());
   endtask

   task automatic test_reset();
      stim_t s;
      s = lw(5'd5, 5'd5); s.rst = 1'b1; s.branch = 1'b1; s.mem_req = 1'b1;
      add(s, C_NONE, 16'd0);
      add(s, C_NONE, 16'd0);
      add(idle(), C_NONE, 16'd0);
      for (int i = 0; i < st_q.size(); i++) begin
         apply(st_q[i]); sb.push_back(ex_q[i]);
         @(negedge clk); e = sb.pop_front(); checks++;
         if (ctl !== e.ctl || stall_cnt !== e.cnt) begin
            errors++;
            $display("FAIL reset[%0d] ctl=%b cnt=%0d expected ctl=%b cnt=%0d", i, ctl, stall_cnt, e.ctl, e.cnt);
         end
         @(posedge clk); #1;
      end
      st_q.delete(); ex_q.delete();
      checks++;
      if (dut.state_q !== RUN) begin
         errors++;
         $display("FAIL reset_state state=%0d expected %0d", dut.state_q, RUN);
      end
   endtask

   task automatic test_load_use();
      stim_t s;
      do_reset();
      add(lw(5'd5, 5'd5), C_LU, 16'd0);
      add(idle(), C_NONE, 16'd1);
      s = lw(5'd9, 5'd3); s.rt = 5'd9;
      add(s, C_NONE, 16'd1);
      s.uses_rt = 1'b1;
      add(s, C_LU, 16'd1);
      add(idle(), C_NONE, 16'd2);
      s = lw(5'd5, 5'd5); s.exe_wb_en = 1'b0;
      add(s, C_NONE, 16'd2);
      s = lw(5'd0, 5'd0); s.uses_rt = 1'b1; s.mem_wb_en = 1'b1;
      add(s, C_NONE, 16'd2);
      add(idle(), C_NONE, 16'd2);
      for (int i = 0; i < st_q.size(); i++) begin
         apply(st_q[i]); sb.push_back(ex_q[i]);
         @(negedge clk); e = sb.pop_front(); checks++;
         if (ctl !== e.ctl || stall_cnt !== e.cnt) begin
            errors++;
            $display("FAIL load_use[%0d] ctl=%b cnt=%0d expected ctl=%b cnt=%0d", i, ctl, stall_cnt, e.ctl, e.cnt);
         end
         @(posedge clk); #1;
      end
      st_q.delete(); ex_q.delete();
   endtask

   task automatic test_branch();
      stim_t s;
      do_reset();
      s = lw(5'd4, 5'd4); s.branch = 1'b1;
      add(s, C_BR, 16'd0);
      s = idle(); s.branch = 1'b1;
      add(s, C_BR, 16'd0);
      add(idle(), C_NONE, 16'd0);
      // branch arriving while frozen is held off until memory is ready
      s = lw(5'd4, 5'd4); s.branch = 1'b1; s.mem_req = 1'b1;
      add(s, C_FRZ, 16'd0);
      s = idle(); s.branch = 1'b1;
      add(s, C_FRZ, 16'd1);
      s.mem_ready = 1'b1;
      add(s, C_BR, 16'd2);
      add(idle(), C_NONE, 16'd2);
      for (int i = 0; i < st_q.size(); i++) begin
         apply(st_q[i]); sb.push_back(ex_q[i]);
         @(negedge clk); e = sb.pop_front(); checks++;
         if (ctl !== e.ctl || stall_cnt !== e.cnt) begin
            errors++;
            $display("FAIL branch[%0d] ctl=%b cnt=%0d expected ctl=%b cnt=%0d", i, ctl, stall_cnt, e.ctl, e.cnt);
         end
         @(posedge clk); #1;
      end
      st_q.delete(); ex_q.delete();
   endtask

   task automatic test_mem_wait();
      stim_t s;
      do_reset();
      s = idle(); s.mem_req = 1'b1; s.mem_ready = 1'b1;
      add(s, C_NONE, 16'd0);
      s.mem_ready = 1'b0;
      add(s, C_FRZ, 16'd0);
      add(s, C_FRZ, 16'd1);
      add(s, C_FRZ, 16'd2);
      s.mem_ready = 1'b1;
      add(s, C_NONE, 16'd3);
      add(idle(), C_NONE, 16'd3);
      for (int i = 0; i < st_q.size(); i++) begin
         apply(st_q[i]); sb.push_back(ex_q[i]);
         @(negedge clk); e = sb.pop_front(); checks++;
         if (ctl !== e.ctl || stall_cnt !== e.cnt) begin
            errors++;
            $display("FAIL mem_wait[%0d] ctl=%b cnt=%0d expected ctl=%b cnt=%0d", i, ctl, stall_cnt, e.ctl, e.cnt);
         end
         @(posedge clk); #1;
         if (i == 1) begin
            checks++;
            if (dut.state_q !== MEM_WAIT) begin
               errors++;
               $display("FAIL mem_wait_state state=%0d expected %0d", dut.state_q, MEM_WAIT);
            end
         end
      end
      st_q.delete(); ex_q.delete();
      checks++;
      if (dut.state_q !== RUN) begin
         errors++;
         $display("FAIL mem_wait_exit state=%0d expected %0d", dut.state_q, RUN);
      end
   endtask

   task automatic test_rst_mid_wait();
      stim_t s;
      do_reset();
      s = idle(); s.mem_req = 1'b1;
      add(s, C_FRZ, 16'd0);
      add(idle(), C_FRZ, 16'd1);
      s = lw(5'd6, 5'd6); s.rst = 1'b1; s.branch = 1'b1; s.mem_req = 1'b1;
      add(s, C_NONE, 16'd2);
      add(idle(), C_NONE, 16'd0);
      add(idle(), C_NONE, 16'd0);
      for (int i = 0; i < st_q.size(); i++) begin
         apply(st_q[i]); sb.push_back(ex_q[i]);
         @(negedge clk); e = sb.pop_front(); checks++;
         if (ctl !== e.ctl || stall_cnt !== e.cnt) begin
            errors++;
            $display("FAIL rst_mid_wait[%0d] ctl=%b cnt=%0d expected ctl=%b cnt=%0d", i, ctl, stall_cnt, e.ctl, e.cnt);
         end
         @(posedge clk); #1;
      end
      st_q.delete(); ex_q.delete();
   endtask

   task automatic test_no_forward();
      stim_t s;
      do_reset();
      s = idle(); s.exe_dest = 5'd7; s.exe_wb_en = 1'b1; s.rs = 5'd1; s.rt = 5'd7; s.uses_rt = 1'b1;
      add(s, NOFWD ? C_LU : C_NONE, 16'd0);
      add(idle(), C_NONE, NOFWD ? 16'd1 : 16'd0);
      s = idle(); s.mem_dest = 5'd12; s.mem_wb_en = 1'b1; s.rs = 5'd12;
      add(s, NOFWD ? C_LU : C_NONE, NOFWD ? 16'd1 : 16'd0);
      add(idle(), C_NONE, NOFWD ? 16'd2 : 16'd0);
      for (int i = 0; i < st_q.size(); i++) begin
         apply(st_q[i]); sb.push_back(ex_q[i]);
         @(negedge clk); e = sb.pop_front(); checks++;
         if (ctl !== e.ctl || stall_cnt !== e.cnt) begin
            errors++;
            $display("FAIL no_forward[%0d] ctl=%b cnt=%0d expected ctl=%b cnt=%0d", i, ctl, stall_cnt, e.ctl, e.cnt);
         end
         @(posedge clk); #1;
      end
      st_q.delete(); ex_q.delete();
   endtask

   task automatic test_saturation();
      logic [SW-1:0] sexp;
      do_reset();
      for (int i = 0; i < 10; i++) add(lw(5'd3, 5'd3), C_LU, CW'(i));
      add(idle(), C_NONE, 16'd10);
      for (int i = 0; i < st_q.size(); i++) begin
         apply(st_q[i]); sb.push_back(ex_q[i]);
         sexp = (i > 7) ? SW'(7) : SW'(i);
         @(negedge clk); e = sb.pop_front(); checks++;
         if (ctl !== e.ctl || stall_cnt !== e.cnt) begin
            errors++;
            $display("FAIL saturation[%0d] ctl=%b cnt=%0d expected ctl=%b cnt=%0d", i, ctl, stall_cnt, e.ctl, e.cnt);
         end
         checks++;
         if (s_stall_cnt !== sexp) begin
            errors++;
            $display("FAIL sat_cnt[%0d] cnt=%0d expected %0d", i, s_stall_cnt, sexp);
         end
         @(posedge clk); #1;
      end
      st_q.delete(); ex_q.delete();
   endtask

   initial begin
      do_reset();
      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_rst_mid_wait();
      test_no_forward();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-file address width.
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have ports id_rs/id_rt, input, REG_ADDR_W, source registers of the instruction in ID.
REQ-006 SHALL have port id_uses_rt, input, 1, ID instruction reads rt (R-type, store, branch).
REQ-007 SHALL have ports exe_dest, exe_wb_en, exe_mem_read, input, REG_ADDR_W/1/1, EXE-stage destination, write-back enable, load flag.
REQ-008 SHALL have ports mem_dest, mem_wb_en, input, REG_ADDR_W/1, MEM-stage destination, write-back enable.
REQ-009 SHALL have port branch_taken, input, 1, branch resolved taken in EXE.
REQ-010 SHALL have ports mem_req, mem_ready, input, 1/1, data-memory access pending / completed this cycle.
REQ-011 SHALL have outputs pc_hold, if2id_hold, if2id_flush, id2exe_hold, id2exe_bubble, exe2mem_hold, 1 bit each, pipeline-register control.
REQ-012 SHALL have output stall_cnt, CNT_W, saturating count of cycles with pc_hold high.

Function
REQ-013 SHALL implement two states: RUN, MEM_WAIT.
REQ-014 RUN->MEM_WAIT when mem_req=1 and mem_ready=0; MEM_WAIT->RUN on the cycle mem_ready=1.
REQ-015 Freeze condition: (state=RUN and mem_req and !mem_ready) or (state=MEM_WAIT and !mem_ready); freeze drives pc_hold, if2id_hold, id2exe_hold, exe2mem_hold =1 and all flush/bubble =0, combinationally.
REQ-016 Load-use hazard: exe_mem_read and exe_wb_en and exe_dest!=0 and (exe_dest==id_rs or (id_uses_rt and exe_dest==id_rt)).
REQ-017 Load-use hazard without freeze or branch SHALL assert pc_hold, if2id_hold, id2exe_bubble for exactly that cycle (one-bubble latency).
REQ-018 branch_taken without freeze SHALL assert if2id_flush and id2exe_bubble for one cycle, pc_hold=0; branch overrides load-use.
REQ-019 Priority: freeze > branch > load-use > none.
REQ-020 branch_taken during freeze SHALL be ignored; flush occurs in the first unfrozen cycle in which branch_taken is still high.
REQ-021 Register 0 SHALL never create a hazard.
REQ-022 stall_cnt SHALL increment by 1 each cycle pc_hold=1, saturate at all-ones, never wrap.

Reset
REQ-023 While rst=1 at an edge: state<=RUN, stall_cnt<=0.
REQ-024 While rst=1 all hold/flush/bubble outputs SHALL be 0 regardless of inputs; reset mid-MEM_WAIT returns to RUN.

Configuration
REQ-025 Macro NO_FORWARD_STALL_EN: when defined, hazard of REQ-016 additionally covers any exe_wb_en RAW (not only loads) and any mem_wb_en RAW on mem_dest, each stalling one cycle per REQ-017; when undefined, only REQ-016 load-use stalls (forwarding present).

Structure
REQ-026 State enum, REG_ADDR_W default and CNT_W default SHALL live in the shared defines package alongside REG_FILE_ADDR_LEN.
REQ-027 Hazard comparison SHALL be a sub-module raw_hazard_cmp (src vs dest match, zero-register filter), instantiated once or thrice per configuration.

Verification
REQ-028 exe: lw dest=5; id_rs=5 -> cycle 1 pc_hold=1, if2id_hold=1, id2exe_bubble=1; next cycle (exe_mem_read=0) all 0; stall_cnt=1.
REQ-029 exe: lw dest=0; id_rs=0 -> no stall.
REQ-030 branch_taken=1 with simultaneous load-use -> if2id_flush=1, id2exe_bubble=1, pc_hold=0.
REQ-031 mem_req=1, mem_ready=0 for 3 cycles then 1 -> all holds 1 for 3 cycles, state MEM_WAIT, RUN after ready, stall_cnt=3.
REQ-032 rst=1 during MEM_WAIT -> outputs 0, state RUN, stall_cnt=0 next cycle.
REQ-033 NO_FORWARD_STALL_EN defined, exe add dest=7, id_rt=7, id_uses_rt=1 -> one-cycle stall; undefined -> none. Force stall_cnt to all-ones -> remains all-ones.
